// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus the instruction-cache frame and FSM definitions.
// ITAG_W/IIDX_W are derived from the default 16-frame icache geometry.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  localparam int ISETS  = 16;
  localparam int IIDX_W = $clog2(ISETS);
  localparam int ITAG_W = WORD_W - IIDX_W - 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

endpackage

// File: rtl/icache_frame_array.sv
// Frame storage for the direct-mapped icache: combinational read by index,
// posedge write, valid bits cleared asynchronously on nRST.
module icache_frame_array
  import cpu_types_pkg::*;
#(
  parameter int SETS = ISETS,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic [IDX_W-1:0] ridx,
  output icache_frame_t rframe,
  input  logic          we,
  input  logic [IDX_W-1:0] widx,
  input  icache_frame_t wframe
);

  logic [SETS-1:0]   valid_r;
  logic [ITAG_W-1:0] tag_r  [SETS];
  word_t             data_r [SETS];

  // valid bits: the only state that must be cleared on reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_r <= '0;
    end else if (we) begin
      valid_r[widx] <= wframe.valid;
    end
  end

  // tag/data payload; never observed while its valid bit is clear
  always_ff @(posedge CLK) begin
    if (we) begin
      tag_r[widx]  <= wframe.tag;
      data_r[widx] <= wframe.data;
    end
  end

  // read port
  always_comb begin
    rframe = {valid_r[ridx], tag_r[ridx], data_r[ridx]};
  end

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: same-cycle hits, single-word
// fill on a miss; a fill always completes to the latched miss address.
module icache_direct_mapped
  import cpu_types_pkg::*;
#(
  parameter int SETS = ISETS
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
);

  localparam int IDX_W = $clog2(SETS);

  icache_state_t     state_r;
  icache_state_t     state_nxt_s;
  word_t             miss_addr_r;
  logic [IDX_W-1:0]  idx_s;
  logic [IDX_W-1:0]  fill_idx_s;
  logic [ITAG_W-1:0] tag_s;
  logic [ITAG_W-1:0] fill_tag_s;
  icache_frame_t     rd_frame_s;
  icache_frame_t     wr_frame_s;
  logic              hit_s;
  logic              miss_s;
  logic              fill_done_s;

  icache_frame_array #(.SETS(SETS)) u_frames (
    .CLK    (CLK),
    .nRST   (nRST),
    .ridx   (idx_s),
    .rframe (rd_frame_s),
    .we     (fill_done_s),
    .widx   (fill_idx_s),
    .wframe (wr_frame_s)
  );

  // address split, hit compare and fill write frame
  always_comb begin
    idx_s       = imemaddr[IDX_W+1:2];
    tag_s       = ITAG_W'(imemaddr[WORD_W-1:IDX_W+2]);
    fill_idx_s  = miss_addr_r[IDX_W+1:2];
    fill_tag_s  = ITAG_W'(miss_addr_r[WORD_W-1:IDX_W+2]);
    hit_s       = (state_r == IDLE) && imemREN && rd_frame_s.valid &&
                  (rd_frame_s.tag == tag_s);
    miss_s      = (state_r == IDLE) && imemREN && !hit_s;
    fill_done_s = (state_r == FILL) && !iwait;
    wr_frame_s  = '{valid: 1'b1, tag: fill_tag_s, data: iload};
  end

  // next-state logic; FILL has no cancel path, only memory completion exits
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (miss_s) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FILL: begin
        if (!iwait) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FILL;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state and latched miss address
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r     <= IDLE;
      miss_addr_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      if (miss_s) begin
        miss_addr_r <= {imemaddr[WORD_W-1:2], 2'b00};
      end
    end
  end

  // output muxing; imemload is forced to zero whenever ihit is low
  always_comb begin
    ihit = hit_s;
    if (hit_s) begin
      imemload = rd_frame_s.data;
    end else begin
      imemload = 32'h0000_0000;
    end
    iREN = (state_r == FILL);
    if (state_r == FILL) begin
      iaddr = miss_addr_r;
    end else begin
      iaddr = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped: address-level cache model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_icache_direct_mapped;

  localparam int SETS = 16;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;
  int cnt;

  // model: which word address each frame holds, and any outstanding fill
  bit          m_val  [SETS];
  logic [31:0] m_addr [SETS];
  logic [31:0] m_data [SETS];
  bit          m_fill;
  logic [31:0] m_miss;

  icache_direct_mapped #(.SETS(SETS)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  always #5 CLK = ~CLK;

  function automatic int idx_of(logic [31:0] a);
    return int'(a[31:2]) % SETS;
  endfunction

  function automatic logic [31:0] walign(logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic bit m_hit();
    return !m_fill && imemREN && m_val[idx_of(imemaddr)] &&
           (m_addr[idx_of(imemaddr)] == walign(imemaddr));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // model update on the same edge the DUT uses
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) m_val[i] <= 1'b0;
      m_fill <= 1'b0;
    end else if (m_fill) begin
      if (!iwait) begin
        m_val[idx_of(m_miss)]  <= 1'b1;
        m_addr[idx_of(m_miss)] <= m_miss;
        m_data[idx_of(m_miss)] <= iload;
        m_fill <= 1'b0;
      end
    end else if (imemREN && !m_hit()) begin
      m_fill <= 1'b1;
      m_miss <= walign(imemaddr);
    end
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    if (cmp_en && nRST) begin
      chk1("cyc_ihit", ihit, m_hit());
      chk("cyc_imemload", imemload, m_hit() ? m_data[idx_of(imemaddr)] : 32'h0);
      chk1("cyc_iREN", iREN, m_fill);
      if (m_fill) chk("cyc_iaddr", iaddr, m_miss);
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // miss on addr, nwait busy cycles, complete with data, then expect the hit
  task automatic fill(logic [31:0] addr, logic [31:0] data, int nwait);
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    #1 chk1("fill_miss_detect", ihit, 1'b0);
    cyc(1);
    repeat (nwait) cyc(1);
    iwait = 1'b0;
    iload = data;
    cyc(1);
    iwait = 1'b1;
    iload = 32'h0;
    #1;
    chk1("fill_then_hit", ihit, 1'b1);
    chk("fill_then_data", imemload, data);
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
    cyc(2);
    chk1("rst_ihit", ihit, 1'b0);
    chk1("rst_iREN", iREN, 1'b0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_imemload", imemload, 32'h0);
    nRST = 1'b1;
    cmp_en = 1'b1;
    cyc(1);

    // reset in the middle of a fill clears all frames, including older ones
    fill(32'h0000_0008, 32'hAAAA_0008, 0);
    imemaddr = 32'h0000_0040;
    cyc(3);
    chk1("t1_in_fill", iREN, 1'b1);
    nRST = 1'b0;
    #1;
    chk1("t1_rst_ihit", ihit, 1'b0);
    chk1("t1_rst_iREN", iREN, 1'b0);
    cyc(1);
    nRST = 1'b1;
    imemaddr = 32'h0000_0008;
    #1 chk1("t1_old_frame_cleared", ihit, 1'b0);
    imemaddr = 32'h0000_0040;
    #1 chk1("t1_refetch_miss", ihit, 1'b0);
    imemREN = 1'b0;
    cyc(1);

    // cold miss: 3 busy cycles, then data; iREN held for 4 cycles
    imemaddr = 32'h0000_0040; imemREN = 1'b1; iwait = 1'b1; cnt = 0;
    #1 chk1("t2_detect", ihit, 1'b0);
    cyc(1);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        iwait = 1'b0;
        iload = 32'h2401_0005;
      end
      #1;
      if (iREN && iaddr == 32'h0000_0040) cnt++;
      cyc(1);
    end
    iwait = 1'b1; iload = 32'h0;
    #1;
    chk("t2_fill_cycles", cnt, 32'd4);
    chk1("t2_hit", ihit, 1'b1);
    chk("t2_data", imemload, 32'h2401_0005);

    // hit after fill
    imemREN = 1'b0;
    cyc(3);
    imemREN = 1'b1; imemaddr = 32'h0000_0040;
    #1;
    chk1("t3_hit", ihit, 1'b1);
    chk1("t3_no_iREN", iREN, 1'b0);
    cyc(1);
    chk1("t3_still_no_iREN", iREN, 1'b0);

    // conflict on index 0
    fill(32'h0000_0000, 32'h1111_0000, 1);
    fill(32'h0000_0040, 32'h2401_0005, 0);
    fill(32'h0000_0000, 32'h1111_0000, 2);

    // redirect during a fill to an aliasing address
    imemaddr = 32'h0000_0080; imemREN = 1'b1; iwait = 1'b1;
    cyc(1);
    imemaddr = 32'h0000_0100;
    cyc(2);
    chk("t5_iaddr_kept", iaddr, 32'h0000_0080);
    iwait = 1'b0; iload = 32'h8080_0080;
    cyc(1);
    iwait = 1'b1; iload = 32'h0;
    #1 chk1("t5_new_addr_miss", ihit, 1'b0);
    cyc(1);
    chk("t5_iaddr_new", iaddr, 32'h0000_0100);
    iwait = 1'b0; iload = 32'h0100_0100;
    cyc(1);
    iwait = 1'b1; iload = 32'h0;
    #1 chk("t5_new_data", imemload, 32'h0100_0100);

    // redirect to a different index, with imemREN dropped during the fill
    imemaddr = 32'h0000_0084;
    cyc(1);
    imemaddr = 32'h0000_0108; imemREN = 1'b0;
    cyc(2);
    iwait = 1'b0; iload = 32'h8484_0084;
    cyc(1);
    iwait = 1'b1; iload = 32'h0; imemREN = 1'b1;
    #1 chk1("t5b_miss_108", ihit, 1'b0);
    cyc(1);
    iwait = 1'b0; iload = 32'h0108_0108;
    cyc(1);
    iwait = 1'b1; iload = 32'h0;
    #1 chk("t5b_data_108", imemload, 32'h0108_0108);
    imemaddr = 32'h0000_0084;
    #1;
    chk1("t5b_kept_hit", ihit, 1'b1);
    chk("t5b_kept_data", imemload, 32'h8484_0084);

    // no request means no hit; offset bits are ignored
    imemREN = 1'b0;
    #1;
    chk1("t6_noren_ihit", ihit, 1'b0);
    chk("t6_noren_load", imemload, 32'h0);
    chk1("t6_noren_iREN", iREN, 1'b0);
    cyc(1);
    fill(32'h0000_0040, 32'h2401_0005, 0);
    imemaddr = 32'h0000_0043;
    #1;
    chk1("t6_offset_hit", ihit, 1'b1);
    chk("t6_offset_data", imemload, 32'h2401_0005);
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
